// File: rtl/pe_nz_scheduler_pkg.sv
// Shared types, widths and idle-pattern constants for the sparse-PE non-zero scheduler.
`ifndef C_LOG_2
`define C_LOG_2(n) ($clog2(n))
`endif

package pe_nz_scheduler_pkg;

    localparam int MAC_DIM    = 4;
    localparam int SPAD_WIDTH = 64;
    localparam int ADDR_WIDTH = `C_LOG_2(SPAD_WIDTH);
    localparam int NUM_NODES  = 20;
    localparam int TAG_WIDTH  = `C_LOG_2(NUM_NODES);
    localparam int CNT_WIDTH  = `C_LOG_2(MAC_DIM + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Lane k sits at bits [(k+1)*ADDR_WIDTH-1 : k*ADDR_WIDTH] once flattened.
    typedef logic [MAC_DIM-1:0][ADDR_WIDTH-1:0] lanes_t;

    localparam lanes_t     IDLE_ADDR = '0;
    localparam logic [1:0] IDLE_NUM  = 2'd0;
    localparam logic       IDLE_ACC  = 1'b0;
    localparam logic       IDLE_DONE = 1'b0;

    // An empty beat still reports one lane (address 0), so the encoding saturates at 0.
    function automatic logic [1:0] lanes_to_num(input logic [CNT_WIDTH-1:0] used);
        return (used == '0) ? 2'd0 : 2'(used - CNT_WIDTH'(1));
    endfunction

endpackage

// File: rtl/pe_nz_scheduler_if.sv
// Job and PE-side signals of the non-zero scheduler; slave is the scheduler's view.
interface pe_nz_scheduler_if;
    import pe_nz_scheduler_pkg::*;

    logic                          job_valid;
    logic                          job_ready;
    logic [SPAD_WIDTH-1:0]         job_mask;
    logic [TAG_WIDTH-1:0]          job_tag;
    logic [ADDR_WIDTH*MAC_DIM-1:0] non_zero_add_out;
    logic [1:0]                    non_zero_num;
    logic                          acc;
    logic                          done;
    logic                          pe_sum_vd;
    logic [TAG_WIDTH-1:0]          tag_out;
    logic                          tag_vd;
    logic                          busy;

    modport slave (
        input  job_valid, job_mask, job_tag, pe_sum_vd,
        output job_ready, non_zero_add_out, non_zero_num, acc, done, tag_out, tag_vd, busy
    );

    modport master (
        output job_valid, job_mask, job_tag, pe_sum_vd,
        input  job_ready, non_zero_add_out, non_zero_num, acc, done, tag_out, tag_vd, busy
    );

endinterface

// File: rtl/pe_nz_scheduler_nz_pick4.sv
// Combinational picker: lowest four set bits of a mask, their count, and the mask with them cleared.
module nz_pick4
    import pe_nz_scheduler_pkg::*;
(
    input  logic [SPAD_WIDTH-1:0] mask,
    output lanes_t                addr,
    output logic [CNT_WIDTH-1:0]  used,
    output logic [SPAD_WIDTH-1:0] rest
);

    logic [SPAD_WIDTH-1:0] work;
    logic [ADDR_WIDTH-1:0] pos;
    logic                  found;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path leaves a latch behind.
        addr  = IDLE_ADDR;
        used  = '0;
        work  = mask;
        pos   = '0;
        found = 1'b0;
        for (int k = 0; k < MAC_DIM; k++) begin
            found = 1'b0;
            pos   = '0;
            // Descending scan with last-hit-wins leaves the lowest set index in pos.
            for (int i = SPAD_WIDTH - 1; i >= 0; i--) begin
                if (work[i]) begin
                    found = 1'b1;
                    pos   = ADDR_WIDTH'(i);
                end
            end
            if (found) begin
                addr[k]   = pos;
                work[pos] = 1'b0;
                used      = used + CNT_WIDTH'(1);
            end
        end
        rest = work;
    end

endmodule

// File: rtl/pe_nz_scheduler.sv
// Scans a job's non-zero bitmap into 4-lane PE issue beats, then returns the node tag with the PE result.
module pe_nz_scheduler
    import pe_nz_scheduler_pkg::*;
(
    input logic              clk,
    input logic              reset,
    pe_nz_scheduler_if.slave bus
);

    state_t                state, state_next;
    logic [SPAD_WIDTH-1:0] rem_mask, rem_mask_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    lanes_t                addr_q, addr_d;
    logic [1:0]            num_q, num_d;
    logic                  acc_q, acc_d;
    logic                  done_q, done_d;
    logic                  tag_vd_q, tag_vd_d;
    logic [TAG_WIDTH-1:0]  tag_out_q, tag_out_d;
    logic                  job_ready_q, busy_q;

    logic                  accept;
    logic [SPAD_WIDTH-1:0] pick_in, pick_rest;
    lanes_t                pick_addr;
    logic [CNT_WIDTH-1:0]  pick_used;

    assign accept = bus.job_valid && job_ready_q;

    // The first beat is built straight from the offered mask so it is on the outputs the cycle after accept.
    assign pick_in = (state == IDLE) ? bus.job_mask : rem_mask;

    nz_pick4 u_pick (
        .mask (pick_in),
        .addr (pick_addr),
        .used (pick_used),
        .rest (pick_rest)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state       <= IDLE;
            rem_mask    <= '0;
            tag_q       <= '0;
            addr_q      <= IDLE_ADDR;
            num_q       <= IDLE_NUM;
            acc_q       <= IDLE_ACC;
            done_q      <= IDLE_DONE;
            tag_vd_q    <= 1'b0;
            tag_out_q   <= '0;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            rem_mask    <= rem_mask_d;
            tag_q       <= tag_d;
            addr_q      <= addr_d;
            num_q       <= num_d;
            acc_q       <= acc_d;
            done_q      <= done_d;
            tag_vd_q    <= tag_vd_d;
            tag_out_q   <= tag_out_d;
            job_ready_q <= (state_next == IDLE);
            busy_q      <= (state_next != IDLE);
        end
    end

    // DRAIN is held through the tag_vd cycle so job_ready only returns the cycle after.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = ISSUE;
            ISSUE:   if (done_q)   state_next = DRAIN;
            DRAIN:   if (tag_vd_q) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_comb begin
        rem_mask_d = rem_mask;
        tag_d      = tag_q;
        addr_d     = IDLE_ADDR;
        num_d      = IDLE_NUM;
        acc_d      = IDLE_ACC;
        done_d     = IDLE_DONE;
        tag_vd_d   = 1'b0;
        tag_out_d  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    tag_d      = bus.job_tag;
                    rem_mask_d = pick_rest;
                    addr_d     = pick_addr;
                    num_d      = lanes_to_num(pick_used);
                    acc_d      = 1'b0;
                    done_d     = (pick_rest == '0);
                end
            end
            ISSUE: begin
                if (!done_q) begin
                    rem_mask_d = pick_rest;
                    addr_d     = pick_addr;
                    num_d      = lanes_to_num(pick_used);
                    acc_d      = 1'b1;
                    done_d     = (pick_rest == '0);
                end
            end
            DRAIN: begin
                if (!tag_vd_q && bus.pe_sum_vd) begin
                    tag_vd_d  = 1'b1;
                    tag_out_d = tag_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.job_ready        = job_ready_q;
    assign bus.non_zero_add_out = addr_q;
    assign bus.non_zero_num     = num_q;
    assign bus.acc              = acc_q;
    assign bus.done             = done_q;
    assign bus.tag_out          = tag_out_q;
    assign bus.tag_vd           = tag_vd_q;
    assign bus.busy             = busy_q;

endmodule

// File: tb/tb_pe_nz_scheduler.sv
// Directed self-checking bench for pe_nz_scheduler: beats, empty/full/top-bit masks, reset and handshake.
module tb_pe_nz_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    pe_nz_scheduler_if bus ();

    pe_nz_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] beat_obs();
        return {bus.non_zero_add_out, bus.non_zero_num, bus.acc, bus.done};
    endfunction

    function automatic logic [27:0] beat_exp(input int a0, input int a1, input int a2, input int a3,
                                             input int num, input bit acc_e, input bit done_e);
        return {6'(a3), 6'(a2), 6'(a1), 6'(a0), 2'(num), acc_e, done_e};
    endfunction

    task automatic start_job(input logic [63:0] m, input logic [4:0] t);
        int waited = 0;
        bus.job_valid = 1'b1;
        bus.job_mask  = m;
        bus.job_tag   = t;
        while (bus.job_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.job_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_job_ready: job_ready=%b after %0d cycles, required 1", bus.job_ready, waited);
        end
        tick();
        bus.job_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] got;
        reset = 1'b0;
        tick();
        tick();
        got = {bus.job_ready, bus.non_zero_add_out, bus.non_zero_num, bus.acc, bus.done,
               bus.tag_out, bus.tag_vd, bus.busy};
        n_checks++;
        if (got !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h required 0", got);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({bus.job_ready, bus.busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release_ready: {ready,busy}=%b required 10", {bus.job_ready, bus.busy});
        end
    endtask

    task automatic test_sparse();
        logic [63:0] m = '0;
        m[0] = 1'b1; m[2] = 1'b1; m[8] = 1'b1; m[9] = 1'b1;
        m[10] = 1'b1; m[11] = 1'b1; m[32] = 1'b1;
        start_job(m, 5'd7);
        n_checks++;
        if (beat_obs() !== beat_exp(0, 2, 8, 9, 3, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL sparse_beat1: got %h required %h", beat_obs(), beat_exp(0, 2, 8, 9, 3, 1'b0, 1'b0));
        end
        n_checks++;
        if ({bus.job_ready, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL sparse_issue_ready: {ready,busy}=%b required 01", {bus.job_ready, bus.busy});
        end
        tick();
        n_checks++;
        if (beat_obs() !== beat_exp(10, 11, 32, 0, 2, 1'b1, 1'b1)) begin
            n_fail++;
            $display("FAIL sparse_beat2: got %h required %h", beat_obs(), beat_exp(10, 11, 32, 0, 2, 1'b1, 1'b1));
        end
        tick();
        n_checks++;
        if ({beat_obs(), bus.tag_vd, bus.job_ready} !== 30'h0) begin
            n_fail++;
            $display("FAIL sparse_drain_idle: got %h required 0", {beat_obs(), bus.tag_vd, bus.job_ready});
        end
        bus.pe_sum_vd = 1'b1;
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if ({bus.tag_vd, bus.tag_out, bus.job_ready} !== {1'b1, 5'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL sparse_tag: {vd,tag,ready}=%b required 1_00111_0", {bus.tag_vd, bus.tag_out, bus.job_ready});
        end
        tick();
        n_checks++;
        if ({bus.tag_vd, bus.job_ready, bus.busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL sparse_back_idle: {vd,ready,busy}=%b required 010", {bus.tag_vd, bus.job_ready, bus.busy});
        end
    endtask

    task automatic test_empty();
        start_job(64'h0, 5'd3);
        n_checks++;
        if (beat_obs() !== beat_exp(0, 0, 0, 0, 0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL empty_beat: got %h required %h", beat_obs(), beat_exp(0, 0, 0, 0, 0, 1'b0, 1'b1));
        end
        tick();
        tick();
        n_checks++;
        if ({beat_obs(), bus.tag_vd, bus.busy} !== {28'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL empty_drain_wait: got %h required 1", {beat_obs(), bus.tag_vd, bus.busy});
        end
        bus.pe_sum_vd = 1'b1;
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if ({bus.tag_vd, bus.tag_out} !== {1'b1, 5'd3}) begin
            n_fail++;
            $display("FAIL empty_tag: {vd,tag}=%b required 1_00011", {bus.tag_vd, bus.tag_out});
        end
        tick();
        n_checks++;
        if ({bus.tag_vd, bus.job_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL empty_back_idle: {vd,ready}=%b required 01", {bus.tag_vd, bus.job_ready});
        end
    endtask

    task automatic test_full();
        logic [27:0] e;
        start_job('1, 5'd19);
        for (int b = 0; b < 16; b++) begin
            e = beat_exp(4*b, 4*b+1, 4*b+2, 4*b+3, 3, (b != 0), (b == 15));
            n_checks++;
            if (beat_obs() !== e) begin
                n_fail++;
                $display("FAIL full_beat%0d: got %h required %h", b + 1, beat_obs(), e);
            end
            tick();
        end
        n_checks++;
        if ({beat_obs(), bus.busy} !== {28'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_drain: got %h required 1", {beat_obs(), bus.busy});
        end
        bus.pe_sum_vd = 1'b1;
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if ({bus.tag_vd, bus.tag_out} !== {1'b1, 5'd19}) begin
            n_fail++;
            $display("FAIL full_tag: {vd,tag}=%b required 1_10011", {bus.tag_vd, bus.tag_out});
        end
        tick();
    endtask

    task automatic test_single_top();
        logic [63:0] m = '0;
        m[63] = 1'b1;
        start_job(m, 5'd12);
        n_checks++;
        if (beat_obs() !== beat_exp(63, 0, 0, 0, 0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL top_bit_beat: got %h required %h", beat_obs(), beat_exp(63, 0, 0, 0, 0, 1'b0, 1'b1));
        end
        tick();
        bus.pe_sum_vd = 1'b1;
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if ({bus.tag_vd, bus.tag_out} !== {1'b1, 5'd12}) begin
            n_fail++;
            $display("FAIL top_bit_tag: {vd,tag}=%b required 1_01100", {bus.tag_vd, bus.tag_out});
        end
        tick();
    endtask

    task automatic test_reset_mid_job();
        logic [35:0] got;
        logic [63:0] m = '0;
        start_job('1, 5'd5);
        tick();
        tick();
        n_checks++;
        if (beat_obs() !== beat_exp(8, 9, 10, 11, 3, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL midreset_beat3: got %h required %h", beat_obs(), beat_exp(8, 9, 10, 11, 3, 1'b1, 1'b0));
        end
        reset = 1'b0;
        tick();
        got = {bus.job_ready, bus.non_zero_add_out, bus.non_zero_num, bus.acc, bus.done,
               bus.tag_out, bus.tag_vd, bus.busy};
        n_checks++;
        if (got !== 36'h0) begin
            n_fail++;
            $display("FAIL midreset_values: got %h required 0", got);
        end
        reset = 1'b1;
        bus.pe_sum_vd = 1'b1;
        tick();
        n_checks++;
        if ({bus.job_ready, bus.busy, bus.tag_vd} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_release: {ready,busy,vd}=%b required 100", {bus.job_ready, bus.busy, bus.tag_vd});
        end
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if (bus.tag_vd !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_tag: tag_vd=%b required 0", bus.tag_vd);
        end
        m[5] = 1'b1;
        start_job(m, 5'd9);
        n_checks++;
        if (beat_obs() !== beat_exp(5, 0, 0, 0, 0, 1'b0, 1'b1)) begin
            n_fail++;
            $display("FAIL midreset_new_job: got %h required %h", beat_obs(), beat_exp(5, 0, 0, 0, 0, 1'b0, 1'b1));
        end
        tick();
        bus.pe_sum_vd = 1'b1;
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if ({bus.tag_vd, bus.tag_out} !== {1'b1, 5'd9}) begin
            n_fail++;
            $display("FAIL midreset_new_tag: {vd,tag}=%b required 1_01001", {bus.tag_vd, bus.tag_out});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] ma = '0;
        logic [63:0] mb = '0;
        ma[1] = 1'b1; ma[4] = 1'b1;
        mb[7] = 1'b1;
        start_job(ma, 5'd2);
        bus.job_valid = 1'b1;
        bus.job_mask  = mb;
        bus.job_tag   = 5'd4;
        n_checks++;
        if ({beat_obs(), bus.job_ready} !== {beat_exp(1, 4, 0, 0, 1, 1'b0, 1'b1), 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_beat_a: got %h required %h", {beat_obs(), bus.job_ready},
                     {beat_exp(1, 4, 0, 0, 1, 1'b0, 1'b1), 1'b0});
        end
        tick();
        n_checks++;
        if ({bus.job_ready, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_drain_ready: {ready,busy}=%b required 01", {bus.job_ready, bus.busy});
        end
        bus.pe_sum_vd = 1'b1;
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if ({bus.tag_vd, bus.tag_out, bus.job_ready} !== {1'b1, 5'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_tag_a: {vd,tag,ready}=%b required 1_00010_0", {bus.tag_vd, bus.tag_out, bus.job_ready});
        end
        tick();
        n_checks++;
        if ({bus.job_ready, bus.tag_vd} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_ready_after_tag: {ready,vd}=%b required 10", {bus.job_ready, bus.tag_vd});
        end
        tick();
        bus.job_valid = 1'b0;
        n_checks++;
        if ({beat_obs(), bus.job_ready} !== {beat_exp(7, 0, 0, 0, 0, 1'b0, 1'b1), 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_beat_b: got %h required %h", {beat_obs(), bus.job_ready},
                     {beat_exp(7, 0, 0, 0, 0, 1'b0, 1'b1), 1'b0});
        end
        tick();
        bus.pe_sum_vd = 1'b1;
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if ({bus.tag_vd, bus.tag_out} !== {1'b1, 5'd4}) begin
            n_fail++;
            $display("FAIL b2b_tag_b: {vd,tag}=%b required 1_00100", {bus.tag_vd, bus.tag_out});
        end
        tick();
        bus.pe_sum_vd = 1'b1;
        tick();
        bus.pe_sum_vd = 1'b0;
        n_checks++;
        if ({bus.tag_vd, bus.job_ready, bus.busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL idle_spurious_sum: {vd,ready,busy}=%b required 010", {bus.tag_vd, bus.job_ready, bus.busy});
        end
        tick();
        n_checks++;
        if (bus.tag_vd !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_spurious_sum_late: tag_vd=%b required 0", bus.tag_vd);
        end
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.job_mask  = '0;
        bus.job_tag   = '0;
        bus.pe_sum_vd = 1'b0;
        test_reset();
        test_sparse();
        test_empty();
        test_full();
        test_single_top();
        test_reset_mid_job();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
